// File: rtl/shift_reg_driver_pkg.sv
// Shared types and constants for the serial-in/parallel-out register chain driver.
// State encodings are fixed so the display and LED drivers can decode them directly.
package shift_reg_driver_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_LOW_ENC   = 2'd1;
    localparam logic [1:0] ST_HIGH_ENC  = 2'd2;
    localparam logic [1:0] ST_LATCH_ENC = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE_ENC,
        StLow   = ST_LOW_ENC,
        StHigh  = ST_HIGH_ENC,
        StLatch = ST_LATCH_ENC
    } state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Divider for the serial clock: counts DIV cycles while enabled and strikes on the last one.
// Held at zero while disabled so every enabled phase starts from a clean count.
module bit_timer #(
    parameter int unsigned DIV = 4,
    parameter int unsigned CW  = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_div_cnt;
    logic [CW-1:0] w_div_cnt_nxt;
    logic          w_tc;

    assign w_tc = i_en && (r_div_cnt == CW'(DIV - 1));
    assign o_tc = w_tc;

    always_comb begin
        w_div_cnt_nxt = r_div_cnt;
        if (!i_en || w_tc) begin
            w_div_cnt_nxt = '0;
        end else begin
            w_div_cnt_nxt = r_div_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

endmodule

// File: rtl/shift_reg_driver.sv
// Shifts an N-bit word MSB first into an external register chain, then strobes its latch.
// Every output comes straight from a flop; sdata is the MSB of the shift register.
module shift_reg_driver
    import shift_reg_driver_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter int unsigned DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         sclk,
    output logic         sdata,
    output logic         latch
);

    localparam int unsigned BCW = clog2_min1(N);
    localparam int unsigned DCW = clog2_min1(DIV + 1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [N-1:0]   r_shift;
    logic [N-1:0]   w_shift_nxt;
    logic [BCW-1:0] r_bit_cnt;
    logic [BCW-1:0] w_bit_cnt_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_sclk;
    logic           w_sclk_nxt;
    logic           r_latch;
    logic           w_latch_nxt;
    logic           w_tc;
    logic           w_timer_en;

    assign w_timer_en = (r_state != StIdle);

    bit_timer #(
        .DIV (DIV),
        .CW  (DCW)
    ) u_bit_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_timer_en),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_sclk_nxt    = r_sclk;
        w_latch_nxt   = r_latch;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt   = StLow;
                    w_shift_nxt   = data_in;
                    w_bit_cnt_nxt = BCW'(N - 1);
                    w_busy_nxt    = 1'b1;
                end
            end
            StLow: begin
                if (w_tc) begin
                    w_state_nxt = StHigh;
                    w_sclk_nxt  = 1'b1;
                end
            end
            StHigh: begin
                if (w_tc) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt = StLatch;
                        w_latch_nxt = 1'b1;
                    end else begin
                        // Next bit appears on the same edge sclk falls.
                        w_shift_nxt   = {r_shift[N-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - BCW'(1);
                        w_state_nxt   = StLow;
                    end
                end
            end
            StLatch: begin
                if (w_tc) begin
                    w_state_nxt = StIdle;
                    w_latch_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // Clearing the word keeps sdata low while idle.
                    w_shift_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_latch   <= w_latch_nxt;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sclk  = r_sclk;
    assign sdata = r_shift[N-1];
    assign latch = r_latch;

endmodule

// File: doc/shift_reg_driver.md
SHIFT_REG_DRIVER -- requirements
Module: shift_reg_driver

Interface
REQ-001 Parameter N, default 16: width of the parallel word driven to the external serial-in/parallel-out register chain; legal range 2..64.
REQ-002 Parameter DIV, default 4: clk cycles per serial-clock half-period; legal range 1..256.
REQ-003 Port clk, input, 1, single system clock; all logic updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset; logic is held in reset while low.
REQ-005 Port data_in, input, N, word to transmit; sampled only on an accepted start.
REQ-006 Port start, input, 1, transmit request; accepted only when busy is low.
REQ-007 Port busy, output, 1, high while a word is in flight.
REQ-008 Port done, output, 1, one-cycle pulse marking transfer and latch completion.
REQ-009 Port sclk, output, 1, serial clock to the external chain; the chain samples sdata on the rising edge.
REQ-010 Port sdata, output, 1, serial data, MSB first.
REQ-011 Port latch, output, 1, storage-register strobe to the external chain; outputs update on its rising edge.

Function
REQ-012 All outputs are registered, with no combinational path from any input to any output.
REQ-013 Controller states are IDLE, LOW, HIGH and LATCH.
REQ-014 IDLE: start high at a clk edge captures data_in into the shift register, loads bit_cnt=N-1 and div_cnt=0, sets busy=1 and sdata=data_in[N-1], and moves to LOW.
REQ-015 LOW: sclk=0 for exactly DIV cycles, then moves to HIGH with div_cnt=0.
REQ-016 HIGH: sclk=1 for exactly DIV cycles; at the end, if bit_cnt==0 move to LATCH, else shift left by one, present the next bit on sdata, decrement bit_cnt and return to LOW.
REQ-017 sdata is stable throughout each LOW+HIGH pair, so it changes only while sclk is low.
REQ-018 LATCH: sclk=0 and latch=1 for exactly DIV cycles, then return to IDLE with busy=0 and done=1 for one cycle.
REQ-019 busy is high for exactly 2*DIV*N+DIV consecutive cycles per word.
REQ-020 sclk produces exactly N rising edges per word, and latch produces exactly one pulse per word.
REQ-021 start while busy is high is ignored, and data_in changes while busy do not affect the word in flight.
REQ-022 start in the done cycle is accepted (IDLE), giving back-to-back words with no idle gap beyond that cycle.
REQ-023 sclk, sdata and latch hold 0 in IDLE.
REQ-024 div_cnt is ceil(log2(DIV+1)) bits wide and bit_cnt is ceil(log2(N)) bits wide; no counter wraps during normal operation.

Reset
REQ-025 reset low forces, asynchronously: state=IDLE, busy=0, done=0, sclk=0, sdata=0, latch=0, shift register=0, counters=0.
REQ-026 reset asserted mid-word aborts the word with no latch pulse and no done pulse.
REQ-027 After reset is released, the first start is accepted at the first rising clk edge on which start is high.

Structure
REQ-028 State encodings (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, LATCH=2'd3) are shared constants in the game package, for reuse by the display and LED drivers.
REQ-029 One sub-module, bit_timer, holds div_cnt and issues a one-cycle terminal-count strike every DIV cycles when enabled.
REQ-030 bit_timer uses the same asynchronous active-low reset as shift_reg_driver.

Verification (N=8, DIV=2 unless stated)
REQ-031 Reset, then start=1 with data_in=8'hA5: sdata sampled at the 8 sclk rises = 1,0,1,0,0,1,0,1; busy high 34 cycles; latch high 2 cycles after the 8th sclk fall; done pulses in cycle 35.
REQ-032 Back-to-back: 8'hFF, then start held high through done with data_in=8'h00: the second word starts in the done cycle; the bench observes two latch pulses, and the second word shifts 8 zeros.
REQ-033 Busy-ignore: start and data_in toggled every cycle while busy during an 8'h3C transfer: 8'h3C is shifted exactly and only one done pulse occurs.
REQ-034 Mid-word reset: reset driven low after the 3rd sclk rise of 8'h81: all outputs go to 0 within the same cycle; no latch and no done pulse; the next 8'h81 completes correctly.
REQ-035 Boundary parameters N=2, DIV=1, data 2'b10: sclk toggles every cycle; busy high 5 cycles; sdata=1 then 0.
REQ-036 Check continuously: sdata never changes while sclk is high, and sclk, sdata and latch are 0 whenever busy is 0.
